// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and owns exception/interrupt entry, eret and the interrupt-enable flag.
module multi_cycle_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_R,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    input  logic        int_req,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        data2Mem,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Beq,
    output logic        Signext,
    output logic        WriteEPC,
    output logic        WriteCause,
    output logic        WriteCp0,
    output logic        InTcause,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  MemtoReg,
    output logic [2:0]  PCSource,
    output logic [3:0]  ALU_operation,
    output logic [4:0]  state
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,  S_IF      = 5'd1,  S_ID      = 5'd2,  S_EX_R    = 5'd3,
        S_WB_R    = 5'd4,  S_EX_I    = 5'd5,  S_WB_I    = 5'd6,  S_MA      = 5'd7,
        S_MEM_RD  = 5'd8,  S_WB_LW   = 5'd9,  S_MEM_WR  = 5'd10, S_BR      = 5'd11,
        S_J       = 5'd12, S_JAL     = 5'd13, S_JR      = 5'd14, S_LUI     = 5'd15,
        S_MFC0    = 5'd16, S_MTC0    = 5'd17, S_EXC_SYS = 5'd18, S_EXC_INT = 5'd19,
        S_ERET    = 5'd20
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       data2mem;
        logic       pc_write;
        logic       pc_write_cond;
        logic       beq;
        logic       sext;
        logic       write_epc;
        logic       write_cause;
        logic       write_cp0;
        logic       int_cause;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_dst;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [2:0] mem_to_reg;
        logic [2:0] pc_src;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_XOR = 4'b0011, ALU_NOR = 4'b0100, ALU_SRL = 4'b0101,
                           ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_SLL = 4'b1000,
                           ALU_SRA = 4'b1001, ALU_PA  = 4'b1111;

    state_t     state_q, nxt;
    ctrl_t      ctrl_q, c;
    logic       ie;
    logic [5:0] op, funct;
    logic [4:0] rs;
    logic [3:0] r_alu_op, i_alu_op;
    logic       r_alu_ok, i_sext, ovf_inst, int_pend;
    state_t     done_nxt;

    // Field bits the controller never decodes; the branch outcome is resolved in the datapath.
    logic unused_bits;
    assign unused_bits = ^{Inst_R[20:6], zero, EXC_VECTOR};

    assign op       = Inst_R[31:26];
    assign rs       = Inst_R[25:21];
    assign funct    = Inst_R[5:0];
    assign ovf_inst = ((op == 6'h00) && ((funct == 6'h20) || (funct == 6'h22))) || (op == 6'h08);
    assign int_pend = ie & int_req;
    assign done_nxt = int_pend ? S_EXC_INT : S_IF;

    always_comb begin
        r_alu_op = ALU_ADD;
        r_alu_ok = 1'b1;
        case (funct)
            6'h20:   r_alu_op = ALU_ADD;
            6'h22:   r_alu_op = ALU_SUB;
            6'h24:   r_alu_op = ALU_AND;
            6'h25:   r_alu_op = ALU_OR;
            6'h26:   r_alu_op = ALU_XOR;
            6'h27:   r_alu_op = ALU_NOR;
            6'h2A:   r_alu_op = ALU_SLT;
            6'h00:   r_alu_op = ALU_SLL;
            6'h02:   r_alu_op = ALU_SRL;
            6'h03:   r_alu_op = ALU_SRA;
            default: r_alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        i_alu_op = ALU_ADD;
        i_sext   = 1'b0;
        case (op)
            6'h08:   begin i_alu_op = ALU_ADD; i_sext = 1'b1; end
            6'h0A:   begin i_alu_op = ALU_SLT; i_sext = 1'b1; end
            6'h0C:   i_alu_op = ALU_AND;
            6'h0D:   i_alu_op = ALU_OR;
            6'h0E:   i_alu_op = ALU_XOR;
            default: i_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        nxt = state_q;
        case (state_q)
            S_IDLE:   nxt = S_IF;
            S_IF:     if (MIO_ready) nxt = S_ID;
            S_ID: begin
                case (op)
                    6'h00: begin
                        if ((funct == 6'h08) || (funct == 6'h09)) nxt = S_JR;
                        else if (r_alu_ok)                        nxt = S_EX_R;
                        else                                      nxt = S_EXC_SYS;
                    end
                    6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: nxt = S_EX_I;
                    6'h0F:        nxt = S_LUI;
                    6'h23, 6'h2B: nxt = S_MA;
                    6'h04, 6'h05: nxt = S_BR;
                    6'h02:        nxt = S_J;
                    6'h03:        nxt = S_JAL;
                    6'h10: begin
                        if (rs == 5'b00000)                           nxt = S_MFC0;
                        else if (rs == 5'b00100)                      nxt = S_MTC0;
                        else if ((rs == 5'b10000) && (funct == 6'h18)) nxt = S_ERET;
                        else                                          nxt = S_EXC_SYS;
                    end
                    default:      nxt = S_EXC_SYS;
                endcase
            end
            S_EX_R:   nxt = S_WB_R;
            S_EX_I:   nxt = S_WB_I;
            // Overflow trap outranks a pending interrupt.
            S_WB_R, S_WB_I: nxt = (overflow && ovf_inst) ? S_EXC_SYS : done_nxt;
            S_MA:     nxt = (op == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (MIO_ready) nxt = S_WB_LW;
            S_MEM_WR: if (MIO_ready) nxt = done_nxt;
            default:  nxt = done_nxt;
        endcase
    end

    // Controls are decoded for the state being entered so they register with it.
    always_comb begin
        c = '0;
        case (nxt)
            S_IF: begin
                c.mem_read = 1'b1; c.iord = 1'b1; c.ir_write = 1'b1;
                c.alu_b = 2'b01; c.alu_op = ALU_ADD; c.pc_write = 1'b1;
            end
            S_ID: begin
                c.alu_b = 2'b11; c.alu_op = ALU_ADD;
            end
            S_EX_R: begin
                c.alu_a = 2'b01; c.alu_op = r_alu_op;
            end
            S_WB_R: begin
                c.alu_a = 2'b01; c.alu_op = r_alu_op; c.reg_dst = 2'b01;
                c.reg_write = !(overflow && ovf_inst);
            end
            S_EX_I: begin
                c.alu_a = 2'b01; c.alu_b = 2'b10; c.alu_op = i_alu_op; c.sext = i_sext;
            end
            S_WB_I: begin
                c.alu_a = 2'b01; c.alu_b = 2'b10; c.alu_op = i_alu_op; c.sext = i_sext;
                c.reg_write = !(overflow && ovf_inst);
            end
            S_MA: begin
                c.alu_a = 2'b01; c.alu_b = 2'b10; c.sext = 1'b1; c.alu_op = ALU_ADD;
            end
            S_MEM_RD: c.mem_read = 1'b1;
            S_WB_LW: begin
                c.mem_to_reg = 3'b001; c.reg_write = 1'b1;
            end
            S_MEM_WR: c.mem_write = 1'b1;
            S_BR: begin
                c.alu_a = 2'b01; c.alu_op = ALU_SUB; c.pc_write_cond = 1'b1;
                c.pc_src = 3'b001; c.beq = (op == 6'h04);
            end
            S_J: begin
                c.pc_write = 1'b1; c.pc_src = 3'b010;
            end
            S_JAL: begin
                c.pc_write = 1'b1; c.pc_src = 3'b010; c.reg_write = 1'b1;
                c.reg_dst = 2'b10; c.mem_to_reg = 3'b011;
            end
            S_JR: begin
                c.alu_a = 2'b01; c.alu_op = ALU_PA; c.pc_write = 1'b1; c.pc_src = 3'b011;
                if (funct == 6'h09) begin
                    c.reg_write = 1'b1; c.mem_to_reg = 3'b011; c.reg_dst = 2'b01;
                end
            end
            S_LUI: begin
                c.mem_to_reg = 3'b010; c.reg_write = 1'b1;
            end
            S_MFC0: begin
                c.mem_to_reg = 3'b100; c.reg_write = 1'b1;
            end
            S_MTC0: c.write_cp0 = 1'b1;
            S_EXC_SYS, S_EXC_INT: begin
                c.alu_a = (nxt == S_EXC_SYS) ? 2'b11 : 2'b00;
                c.int_cause = (nxt == S_EXC_INT);
                c.alu_op = ALU_PA; c.write_epc = 1'b1; c.write_cause = 1'b1;
                c.pc_write = 1'b1; c.pc_src = 3'b100;
            end
            S_ERET: begin
                c.pc_write = 1'b1; c.pc_src = 3'b101;
            end
            default: c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            ie      <= 1'b1;
        end else begin
            state_q <= nxt;
            ctrl_q  <= c;
            if ((nxt == S_EXC_SYS) || (nxt == S_EXC_INT)) ie <= 1'b0;
            else if (nxt == S_ERET)                       ie <= 1'b1;
        end
    end

    assign state         = state_q;
    assign IorD          = ctrl_q.iord;
    assign IRWrite       = ctrl_q.ir_write;
    assign RegWrite      = ctrl_q.reg_write;
    assign data2Mem      = ctrl_q.data2mem;
    assign PCWrite       = ctrl_q.pc_write;
    assign PCWriteCond   = ctrl_q.pc_write_cond;
    assign Beq           = ctrl_q.beq;
    assign Signext       = ctrl_q.sext;
    assign WriteEPC      = ctrl_q.write_epc;
    assign WriteCause    = ctrl_q.write_cause;
    assign WriteCp0      = ctrl_q.write_cp0;
    assign InTcause      = ctrl_q.int_cause;
    assign MemRead       = ctrl_q.mem_read;
    assign MemWrite      = ctrl_q.mem_write;
    assign RegDst        = ctrl_q.reg_dst;
    assign ALUSrcA       = ctrl_q.alu_a;
    assign ALUSrcB       = ctrl_q.alu_b;
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign PCSource      = ctrl_q.pc_src;
    assign ALU_operation = ctrl_q.alu_op;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks lw/sw/branch/I-type/exception/interrupt
// sequences and checks state and controls on the falling edge.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Inst_R = 32'h0;
    logic        zero = 1'b0, overflow = 1'b0, MIO_ready = 1'b0, int_req = 1'b0;
    logic        IorD, IRWrite, RegWrite, data2Mem, PCWrite, PCWriteCond, Beq, Signext;
    logic        WriteEPC, WriteCause, WriteCp0, InTcause, MemRead, MemWrite;
    logic [1:0]  RegDst, ALUSrcA, ALUSrcB;
    logic [2:0]  MemtoReg, PCSource;
    logic [3:0]  ALU_operation;
    logic [4:0]  state;

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] ST_IDLE = 5'd0, ST_IF = 5'd1, ST_ID = 5'd2, ST_EX_R = 5'd3,
                           ST_WB_R = 5'd4, ST_EX_I = 5'd5, ST_WB_I = 5'd6, ST_MA = 5'd7,
                           ST_MEM_RD = 5'd8, ST_WB_LW = 5'd9, ST_MEM_WR = 5'd10, ST_BR = 5'd11,
                           ST_EXC_SYS = 5'd18, ST_EXC_INT = 5'd19, ST_ERET = 5'd20;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .Inst_R(Inst_R), .zero(zero), .overflow(overflow),
        .MIO_ready(MIO_ready), .int_req(int_req),
        .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .data2Mem(data2Mem),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Beq(Beq), .Signext(Signext),
        .WriteEPC(WriteEPC), .WriteCause(WriteCause), .WriteCp0(WriteCp0), .InTcause(InTcause),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg), .PCSource(PCSource),
        .ALU_operation(ALU_operation), .state(state)
    );

    always #5 clk = ~clk;

    logic [29:0] outs;
    assign outs = {IorD, IRWrite, RegWrite, data2Mem, PCWrite, PCWriteCond, Beq, Signext,
                   WriteEPC, WriteCause, WriteCp0, InTcause, MemRead, MemWrite,
                   RegDst, ALUSrcA, ALUSrcB, MemtoReg, PCSource, ALU_operation};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [4:0] s);
        @(negedge clk);
        chk(tag, 32'(state), 32'(s));
    endtask

    initial begin
        MIO_ready = 1'b0;
        Inst_R    = 32'h8C43_0004;  // lw $3,4($2)
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", 32'(state), 32'(ST_IDLE));
            chk("rst_outs", 32'(outs), 32'd0);
        end
        reset = 1'b1;

        for (int k = 1; k <= 5; k++) begin
            cyc("if_wait", ST_IF);
            if (k == 1) chk("if_ctl", 32'({IRWrite, PCWrite, MemRead, IorD, ALUSrcB}), 32'b1111_01);
        end
        MIO_ready = 1'b1;
        cyc("lw_id", ST_ID);
        chk("id_ctl", 32'({ALUSrcA, ALUSrcB, ALU_operation}), 32'b00_11_0010);
        MIO_ready = 1'b0;
        cyc("lw_ma", ST_MA);
        chk("ma_ctl", 32'({Signext, ALUSrcA, ALUSrcB}), 32'b1_01_10);
        cyc("mem_rd1", ST_MEM_RD);
        chk("memrd_ctl", 32'({IorD, MemRead}), 32'b01);
        cyc("mem_rd2", ST_MEM_RD);
        cyc("mem_rd3", ST_MEM_RD);
        MIO_ready = 1'b1;
        cyc("wb_lw", ST_WB_LW);
        chk("wblw_ctl", 32'({MemtoReg, RegDst, RegWrite}), 32'b001_00_1);
        cyc("lw_done", ST_IF);

        Inst_R = 32'h1022_0003;  // beq
        zero   = 1'b1;
        cyc("beq_id", ST_ID);
        cyc("beq_br", ST_BR);
        chk("beq_ctl", 32'({PCWriteCond, Beq, PCSource, ALU_operation}), 32'b1_1_001_0110);
        cyc("beq_done", ST_IF);
        Inst_R = 32'h1422_0003;  // bne
        cyc("bne_id", ST_ID);
        cyc("bne_br", ST_BR);
        chk("bne_ctl", 32'({PCWriteCond, Beq, PCSource}), 32'b1_0_001);
        cyc("bne_done", ST_IF);
        zero = 1'b0;

        Inst_R = 32'h2022_FFFF;  // addi
        cyc("addi_id", ST_ID);
        cyc("addi_ex", ST_EX_I);
        chk("addi_ex_ctl", 32'({Signext, ALUSrcB, ALU_operation}), 32'b1_10_0010);
        cyc("addi_wb", ST_WB_I);
        chk("addi_wb_ctl", 32'({RegWrite, RegDst}), 32'b1_00);
        cyc("addi_done", ST_IF);

        Inst_R = 32'h3022_000F;  // andi
        cyc("andi_id", ST_ID);
        cyc("andi_ex", ST_EX_I);
        chk("andi_ex_ctl", 32'({Signext, ALU_operation}), 32'b0_0000);
        int_req = 1'b1;
        cyc("andi_wb", ST_WB_I);
        cyc("exc_int", ST_EXC_INT);
        chk("exc_int_ctl", 32'({InTcause, WriteEPC, WriteCause, ALUSrcA, PCSource}), 32'b1_1_1_00_100);
        cyc("int_masked", ST_IF);
        Inst_R = 32'h4200_0018;  // eret
        cyc("eret_id", ST_ID);
        cyc("eret", ST_ERET);
        chk("eret_ctl", 32'({PCWrite, PCSource}), 32'b1_101);
        cyc("int_after_eret", ST_EXC_INT);
        int_req = 1'b0;
        cyc("int2_done", ST_IF);

        Inst_R = 32'h0022_1820;  // add $3,$1,$2
        cyc("add_id", ST_ID);
        cyc("add_ex", ST_EX_R);
        chk("add_ex_ctl", 32'({ALUSrcA, ALUSrcB, ALU_operation}), 32'b01_00_0010);
        overflow = 1'b1;
        cyc("add_wb", ST_WB_R);
        chk("ovf_regwrite", 32'(RegWrite), 32'd0);
        cyc("ovf_exc", ST_EXC_SYS);
        chk("exc_sys_ctl", 32'({WriteEPC, PCSource, InTcause, ALUSrcA}), 32'b1_100_0_11);
        overflow = 1'b0;
        cyc("ovf_done", ST_IF);

        Inst_R = 32'hFC00_0000;  // unsupported opcode
        cyc("bad_id", ST_ID);
        cyc("bad_exc", ST_EXC_SYS);
        cyc("bad_done", ST_IF);

        Inst_R = 32'hAC43_0004;  // sw $3,4($2)
        cyc("sw_id", ST_ID);
        MIO_ready = 1'b0;
        cyc("sw_ma", ST_MA);
        cyc("sw_mem", ST_MEM_WR);
        chk("memwr_ctl", 32'({MemWrite, IorD, data2Mem}), 32'b100);
        #2 reset = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 32'(ST_IDLE));
        chk("midrst_outs", 32'(outs), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        MIO_ready = 1'b1;
        cyc("rst_if", ST_IF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle MIPS control unit, directly upstream of the datapath; drives every datapath control input each cycle.
- Decodes the latched instruction word (Inst_R) and sequences fetch / decode / execute / memory / writeback.
- Uses the zero, overflow and MIO_ready returns from the datapath and memory.
- Owns exception and interrupt entry, eret, and the interrupt-enable flag.

Parameters:
- EXC_VECTOR, 32'h0000_0004: documentation only; datapath PCSource=100 loads this address.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- Inst_R, input, 32: latched instruction from the datapath.
- zero, input, 1: ALU zero flag, combinational from the datapath.
- overflow, input, 1: ALU signed-overflow flag, combinational from the datapath.
- MIO_ready, input, 1: memory/IO access complete.
- int_req, input, 1: external interrupt, level-sensitive.
- IorD, IRWrite, RegWrite, data2Mem, PCWrite, PCWriteCond, Beq, Signext, WriteEPC, WriteCause, WriteCp0, InTcause: output, 1 each; datapath controls.
- MemRead, MemWrite: output, 1 each; memory strobes.
- RegDst, ALUSrcA, ALUSrcB: output, 2 each.
- MemtoReg, PCSource: output, 3 each.
- ALU_operation: output, 4.
- state: output, 5; current FSM state, for debug display.

Behaviour:
- Output timing: all outputs are registered and take the values of the state being entered on the same edge, so they are valid for the whole of that state.
- Reset: state=IDLE and every output is 0 while reset=0. The interrupt-enable flag ie is set to 1. The first edge after release enters IF.
- ALU_operation encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRA, 1111 pass-A.
- Supported instructions: R-type (add, sub, and, or, xor, nor, slt, sll, srl, sra, jr, jalr, syscall); addi, slti, andi, ori, xori, lui, lw, sw, beq, bne, j, jal, mfc0, mtc0, eret.
- IF:
  - Drives MemRead=1, IorD=1, IRWrite=1, ALUSrcA=00, ALUSrcB=01, ADD, PCSource=000, PCWrite=1.
  - Stays in IF while MIO_ready=0; the datapath gates PC and IR updates on MIO_ready.
  - Leaves for ID on MIO_ready=1.
- Interrupt: if ie=1 and int_req=1 on the cycle IF would be entered, enter EXC_INT instead of IF.
- ID:
  - Drives ALUSrcA=00, ALUSrcB=11, ADD; the branch target lands in ALU_Out.
  - Decodes Inst_R[31:26] and [5:0] into the next state.
  - Any unsupported opcode enters EXC_SYS.
- EX_R: ALUSrcA=01, ALUSrcB=00, op from funct. Always followed by WB_R.
- WB_R:
  - Holds the EX_R ALU controls so overflow stays stable; drives RegDst=01, MemtoReg=000, RegWrite=1.
  - If overflow=1 and funct is add or sub: RegWrite is forced to 0 and the next state is EXC_SYS.
- EX_I / WB_I: same as EX_R / WB_R with ALUSrcB=10 and RegDst=00.
  - Signext=1 for addi and slti; 0 for andi, ori and xori.
  - The overflow rule applies to addi.
- lw / sw address: MA state, ALUSrcA=01, ALUSrcB=10, Signext=1, ADD.
- MEM_RD: IorD=0, MemRead=1. Stays until MIO_ready=1, then WB_LW.
- WB_LW: MemtoReg=001, RegDst=00, RegWrite=1.
- MEM_WR: IorD=0, MemWrite=1, data2Mem=0. Stays until MIO_ready=1, then IF.
- BR: ALUSrcA=01, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=001. Beq=1 for beq, 0 for bne.
- J: PCWrite=1, PCSource=010.
- JAL: as J, plus RegWrite=1, RegDst=10, MemtoReg=011.
- JR: ALUSrcA=01, pass-A, PCWrite=1, PCSource=011. jalr additionally writes rd with MemtoReg=011, RegDst=01.
- LUI: MemtoReg=010, RegDst=00, RegWrite=1.
- MFC0: MemtoReg=100, RegDst=00, RegWrite=1.
- MTC0: WriteCp0=1.
- EXC_SYS:
  - ALUSrcA=11 (PC-4), pass-A, WriteEPC=1, WriteCause=1, InTcause=0, PCWrite=1, PCSource=100.
  - Clears ie.
- EXC_INT: as EXC_SYS but ALUSrcA=00 and InTcause=1.
- ERET: PCWrite=1, PCSource=101; sets ie=1.
- Completion: every terminal state returns to IF, or to EXC_INT when the interrupt condition holds.
- Reset asserted mid-instruction: immediately IDLE with all outputs 0; no partial write strobe may remain high.
- Simultaneous overflow and pending interrupt: EXC_SYS wins. ie is then 0, so the interrupt waits until after eret.

Test Plan:
- Reset low for 3 cycles, then release: all outputs 0 and state=IDLE during reset; IF entered 1 cycle after release with IRWrite=1 and PCWrite=1.
- IF with MIO_ready held 0 for 4 cycles, then 1: state stays IF for 4 cycles; ID follows; total 6 cycles to ID.
- Inst_R=0x8C430004 (lw $3,4($2)), MEM_RD wait of 2 cycles: state sequence IF, ID, MA, MEM_RD×3, WB_LW, IF. WB_LW shows MemtoReg=001, RegDst=00, RegWrite=1.
- Inst_R=0x00221820 (add) with overflow=1 in WB_R: RegWrite=0; next state EXC_SYS with WriteEPC=1, PCSource=100, InTcause=0.
- beq, zero=1: BR shows PCWriteCond=1, Beq=1, PCSource=001. bne: same except Beq=0.
- int_req=1 at instruction completion: EXC_INT with InTcause=1. A second int_req before eret (0x42000018) is ignored; it is taken after ERET returns.
